// File: rtl/wei_fetch_arb.sv
// wei_fetch_arb: round-robin arbiter that lets NUM_REQ weight register files
// share one weight-SRAM read port, keeping exactly one read outstanding.
// Optional WAIT watchdog is built when WEI_FETCH_ARB_TIMEOUT_EN is defined;
// otherwise WAIT waits indefinitely and err is constant low.
module wei_fetch_arb #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WR_NUM     = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    req_rdy,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]         req_addr,
  output logic                                  sram_rd_en,
  output logic [$clog2(NUM_REQ)+ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic                                  sram_rd_val,
  input  logic [DATA_WIDTH*WR_NUM-1:0]          sram_rd_data,
  output logic [NUM_REQ-1:0]                    wei_val,
  output logic [DATA_WIDTH*WR_NUM-1:0]          wei_data,
  output logic                                  busy,
  output logic                                  err
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_q, rr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    en_q, en_d;

  logic                    hit_c;
  logic [IDX_W-1:0]        pick_c;
  logic [IDX_W-1:0]        cand_c;
  logic [ADDR_WIDTH-1:0]   pick_addr_c;

`ifdef WEI_FETCH_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;
`endif

  // Round-robin search: first asserted req_rdy at or above rr_q, wrapping.
  always_comb begin
    hit_c       = 1'b0;
    pick_c      = rr_q;
    cand_c      = rr_q;
    pick_addr_c = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_c = rr_q + IDX_W'(k);
      if (!hit_c && req_rdy[cand_c]) begin
        hit_c  = 1'b1;
        pick_c = cand_c;
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_c == IDX_W'(k)) begin
        pick_addr_c = req_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
      end
    end
  end

  // Next-state, latch updates and same-cycle delivery strobe.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    en_d    = 1'b0;
    wei_val = '0;
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    if (state_q == S_WAIT && sram_rd_val) begin
      wei_val[grant_q] = 1'b1;
    end
    if (reset) begin
      state_d = S_IDLE;
      rr_d    = '0;
      grant_d = '0;
      addr_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (hit_c) begin
            grant_d = pick_c;
            addr_d  = pick_addr_c;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          en_d    = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (sram_rd_val) begin
            rr_d    = grant_q + IDX_W'(1);
            state_d = S_IDLE;
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the read: flag it and move past the stalled requester.
            err_d   = 1'b1;
            rr_d    = grant_q + IDX_W'(1);
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and latched-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign sram_rd_en   = en_q;
  assign sram_rd_addr = {grant_q, addr_q};
  assign wei_data     = sram_rd_data;
  assign busy         = (state_q != S_IDLE);

`ifdef WEI_FETCH_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  // No watchdog in this build: err is constant low and TIMEOUT has no effect.
  assign err = 1'b0 & (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_wei_fetch_arb.sv
// Self-checking bench for wei_fetch_arb: directed table, corner-case sequences
// and a randomized run against a transaction-level reference model.
module tb_wei_fetch_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned WR = 8;
  localparam int unsigned TO = 64;

  logic                 clk;
  logic                 rst_n;
  logic                 reset;
  logic [N-1:0]         req_rdy;
  logic [N*AW-1:0]      req_addr;
  logic                 sram_rd_en;
  logic [2+AW-1:0]      sram_rd_addr;
  logic                 sram_rd_val;
  logic [DW*WR-1:0]     sram_rd_data;
  logic [N-1:0]         wei_val;
  logic [DW*WR-1:0]     wei_data;
  logic                 busy;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  wei_fetch_arb #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .WR_NUM(WR), .ADDR_WIDTH(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .reset(reset),
    .req_rdy(req_rdy), .req_addr(req_addr),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_val(sram_rd_val), .sram_rd_data(sram_rd_data),
    .wei_val(wei_val), .wei_data(wei_data),
    .busy(busy), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One-cycle synchronous clear; leaves the bench in an IDLE cycle.
  task automatic sync_clear();
    tick();
    reset   = 1'b1;
    req_rdy = '0;
    sram_rd_val = 1'b0;
    settle();
    tick();
    reset = 1'b0;
    settle();
  endtask

  // Request for one cycle, then wait (bounded) for the read strobe.
  task automatic grant_wait(input logic [3:0] rdy, input logic [1:0] exp_idx);
    bit seen;
    logic [1:0] idx;
    seen = 1'b0;
    tick();
    req_rdy = rdy;
    settle();
    for (int t = 0; t < 8 && !seen; t++) begin
      tick();
      req_rdy = '0;
      settle();
      if (sram_rd_en) seen = 1'b1;
    end
    chk("strobe_seen", 64'(seen), 64'd1);
    idx = sram_rd_addr[AW +: 2];
    chk("grant_idx", 64'(idx), 64'(exp_idx));
  endtask

  // Return read data lat cycles after the strobe and check delivery.
  task automatic respond(input int lat, input logic [3:0] exp_wv);
    for (int j = 0; j < lat - 1; j++) begin
      tick();
      settle();
      chk("wei_val_waiting", 64'(wei_val), 64'd0);
    end
    tick();
    sram_rd_val  = 1'b1;
    sram_rd_data = {$urandom, $urandom};
    settle();
    chk("wei_val_deliver", 64'(wei_val), 64'(exp_wv));
    chk("wei_data", wei_data, sram_rd_data);
    tick();
    sram_rd_val = 1'b0;
    settle();
    chk("busy_after_deliver", 64'(busy), 64'd0);
    chk("wei_val_after", 64'(wei_val), 64'd0);
  endtask

  typedef struct {
    logic [3:0]    rdy;
    logic [N*AW-1:0] addr;
    int            lat;
    logic [9:0]    exp_addr;
    logic [3:0]    exp_wv;
  } vec_t;

  vec_t vt[6];

  // Reference-model state for the randomized run.
  bit          m_act;
  int          m_g;
  int          m_rr;
  int          m_gi;
  logic [1:0]  m_cur_gi;
  logic [7:0]  m_cur_ga;
  bit          m_err;

  initial begin
    rst_n = 1'b0; reset = 1'b0; req_rdy = '0; req_addr = '0;
    sram_rd_val = 1'b0; sram_rd_data = '0;

    vt[0] = '{4'b0010, 32'h4433_0511, 3, {2'd1, 8'h05}, 4'b0010};
    vt[1] = '{4'b1100, 32'hA0B0_C0D0, 1, {2'd2, 8'hB0}, 4'b0100};
    vt[2] = '{4'b1000, 32'h7F00_0000, 5, {2'd3, 8'h7F}, 4'b1000};
    vt[3] = '{4'b0001, 32'h0000_00FF, 2, {2'd0, 8'hFF}, 4'b0001};
    vt[4] = '{4'b1111, 32'h1234_5678, 4, {2'd0, 8'h78}, 4'b0001};
    vt[5] = '{4'b0100, 32'h00E5_0000, 1, {2'd2, 8'hE5}, 4'b0100};

    // Reset state.
    #12;
    chk("rst_en", 64'(sram_rd_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wei_val", 64'(wei_val), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_addr", 64'(sram_rd_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single-request table from a cleared arbiter.
    for (int i = 0; i < 6; i++) begin
      sync_clear();
      tick();
      req_rdy = vt[i].rdy; req_addr = vt[i].addr;
      settle();
      chk("tbl_busy_idle", 64'(busy), 64'd0);
      tick();
      req_rdy = '0; req_addr = ~vt[i].addr;
      settle();
      chk("tbl_busy_issue", 64'(busy), 64'd1);
      chk("tbl_en_issue", 64'(sram_rd_en), 64'd0);
      tick();
      settle();
      chk("tbl_en", 64'(sram_rd_en), 64'd1);
      chk("tbl_addr", 64'(sram_rd_addr), 64'(vt[i].exp_addr));
      respond(vt[i].lat, vt[i].exp_wv);
    end

    // Round robin with all requesters held.
    begin
      int en_extra;
      sync_clear();
      req_rdy = 4'hF;
      for (int g = 0; g < 5; g++) begin
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
          tick();
          settle();
          if (sram_rd_en) seen = 1'b1;
        end
        chk("rr_strobe_seen", 64'(seen), 64'd1);
        chk("rr_grant_idx", 64'(sram_rd_addr[AW +: 2]), 64'(g % 4));
        tick();
        sram_rd_val = 1'b1;
        if (g == 4) req_rdy = '0;
        settle();
        chk("rr_wei_val", 64'(wei_val), 64'(4'b0001 << (g % 4)));
        tick();
        sram_rd_val = 1'b0;
        settle();
      end
      en_extra = 0;
      for (int t = 0; t < 5; t++) begin
        tick();
        settle();
        if (sram_rd_en || busy) en_extra++;
      end
      chk("rr_no_extra_strobe", 64'(en_extra), 64'd0);
    end

    // Reset in WAIT abandons the read and clears the pointer.
    sync_clear();
    grant_wait(4'b0010, 2'd1);
    respond(2, 4'b0010);
    grant_wait(4'b0100, 2'd2);
    tick();
    reset = 1'b1;
    settle();
    tick();
    reset = 1'b0;
    sram_rd_val = 1'b1;
    settle();
    chk("rstwait_wei_val", 64'(wei_val), 64'd0);
    chk("rstwait_busy", 64'(busy), 64'd0);
    tick();
    sram_rd_val = 1'b0;
    settle();
    chk("rstwait_busy2", 64'(busy), 64'd0);
    grant_wait(4'b1111, 2'd0);
    respond(1, 4'b0001);

    // Stalled read: watchdog or indefinite wait.
    grant_wait(4'b0010, 2'd1);
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
    begin
      int early;
      early = 0;
      for (int t = 1; t < TO; t++) begin
        tick();
        settle();
        if (!busy) early++;
      end
      chk("to_no_early_exit", 64'(early), 64'd0);
      tick();
      settle();
      chk("to_busy", 64'(busy), 64'd0);
      chk("to_err", 64'(err), 64'd1);
      chk("to_wei_val", 64'(wei_val), 64'd0);
      grant_wait(4'b0110, 2'd2);
      respond(1, 4'b0100);
      chk("to_err_sticky", 64'(err), 64'd1);
    end
`else
    for (int t = 0; t < 100; t++) begin
      tick();
      settle();
    end
    chk("nto_busy", 64'(busy), 64'd1);
    chk("nto_err", 64'(err), 64'd0);
    chk("nto_wei_val", 64'(wei_val), 64'd0);
    sync_clear();
`endif

    // Asynchronous rst_n in WAIT clears outputs without a clock edge.
    grant_wait(4'b1000, 2'd3);
    #1;
    rst_n = 1'b0;
    sram_rd_val = 1'b1;
    #1;
    chk("arst_en", 64'(sram_rd_en), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_wei_val", 64'(wei_val), 64'd0);
    chk("arst_err", 64'(err), 64'd0);
    chk("arst_addr", 64'(sram_rd_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sram_rd_val = 1'b0;

    // Stray valid in IDLE.
    tick();
    sram_rd_val = 1'b1;
    settle();
    chk("stray_wei_val", 64'(wei_val), 64'd0);
    chk("stray_busy", 64'(busy), 64'd0);
    tick();
    sram_rd_val = 1'b0;
    settle();
    chk("stray_busy2", 64'(busy), 64'd0);

    // Randomized traffic against a transaction-level model.
    sync_clear();
    m_act = 1'b0; m_g = 0; m_rr = 0; m_gi = 0;
    m_cur_gi = '0; m_cur_ga = '0; m_err = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [3:0] exp_wv;
      logic [9:0] exp_addr;
      bit accept, exp_en, exp_busy;
      tick();
      reset    = ($urandom_range(0, 99) == 0);
      req_rdy  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom);
      req_addr = $urandom;
      sram_rd_data = {$urandom, $urandom};
      if (reset) sram_rd_val = 1'b0;
      else if (m_act && cyc >= m_g + 3)
        sram_rd_val = ((cyc - (m_g + 2)) >= 20) || ($urandom_range(0, 3) == 0);
      else if (m_act && cyc == m_g + 2) sram_rd_val = 1'b0;
      else sram_rd_val = ($urandom_range(0, 7) == 0);
      settle();

      accept   = m_act && (cyc >= m_g + 3) && sram_rd_val && !reset;
      exp_en   = m_act && (cyc == m_g + 2);
      exp_busy = m_act && (cyc > m_g);
      exp_wv   = accept ? 4'(1 << m_gi) : 4'b0;
      exp_addr = {m_cur_gi, m_cur_ga};
      chk("rnd_en", 64'(sram_rd_en), 64'(exp_en));
      chk("rnd_busy", 64'(busy), 64'(exp_busy));
      chk("rnd_wei_val", 64'(wei_val), 64'(exp_wv));
      chk("rnd_addr", 64'(sram_rd_addr), 64'(exp_addr));
      chk("rnd_err", 64'(err), 64'(m_err));
      chk("rnd_wei_data", wei_data, sram_rd_data);

      if (reset) begin
        m_act = 1'b0; m_rr = 0; m_cur_gi = '0; m_cur_ga = '0;
      end else if (accept) begin
        m_act = 1'b0; m_rr = (m_gi + 1) % 4;
`ifdef WEI_FETCH_ARB_TIMEOUT_EN
      end else if (m_act && cyc == m_g + 1 + TO) begin
        m_act = 1'b0; m_err = 1'b1; m_rr = (m_gi + 1) % 4;
`endif
      end else if (!m_act && req_rdy != 4'b0) begin
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = (m_rr + k) % 4;
          if (!m_act && req_rdy[idx]) begin
            m_act = 1'b1; m_g = cyc; m_gi = idx;
            m_cur_gi = 2'(idx);
            m_cur_ga = req_addr[8*idx +: 8];
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wei_fetch_arb.md
WEI_FETCH_ARB -- requirements
Module: wei_fetch_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of weight register files sharing one weight-SRAM read port (power of two, 2..8).
REQ-002 Parameter DATA_WIDTH, default 8: width of one weight.
REQ-003 Parameter WR_NUM, default 8: weights per SRAM word.
REQ-004 Parameter ADDR_WIDTH, default 8: block address width per requester.
REQ-005 Parameter TIMEOUT, default 64: WAIT-state cycle limit; used only under the configuration macro.
REQ-006 clk  in  1  single clock; all state rises on posedge clk.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 reset  in  1  synchronous clear, active-high.
REQ-009 req_rdy  in  NUM_REQ  per-requester "needs next word" (register-file datain_rdy).
REQ-010 req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester block address (register-file datain_addr); slice i = bits [ADDR_WIDTH*i +: ADDR_WIDTH].
REQ-011 sram_rd_en  out  1  one-cycle read strobe.
REQ-012 sram_rd_addr  out  log2(NUM_REQ)+ADDR_WIDTH  read address = {grant index, granted req_addr}.
REQ-013 sram_rd_val  in  1  read data valid; arbitrary latency >=1 cycle after sram_rd_en, at most one pulse per strobe.
REQ-014 sram_rd_data  in  DATA_WIDTH*WR_NUM  read data.
REQ-015 wei_val  out  NUM_REQ  one-hot delivery strobe to the granted requester (register-file datain_val).
REQ-016 wei_data  out  DATA_WIDTH*WR_NUM  delivered word, broadcast to all requesters.
REQ-017 busy  out  1  high when state != IDLE.
REQ-018 err  out  1  sticky timeout flag.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT; exactly one SRAM read outstanding at any time.
REQ-020 IDLE: if reset low and any req_rdy set, grant the first set bit searching from rr_ptr upward with wrap (round-robin); latch grant index and its req_addr; go ISSUE next cycle; else stay.
REQ-021 ISSUE: sram_rd_en=1 for exactly one cycle with sram_rd_addr driven from latched values; go WAIT.
REQ-022 WAIT: on sram_rd_val, wei_val[grant]=1 combinationally the same cycle, wei_data=sram_rd_data; rr_ptr <= grant+1 mod NUM_REQ; go IDLE.
REQ-023 wei_val is zero in all other cycles; wei_data equals sram_rd_data in all cycles.
REQ-024 sram_rd_val in IDLE or ISSUE is ignored (no wei_val, no state change).
REQ-025 Latency: req_rdy seen in IDLE -> sram_rd_en 2 cycles later; sram_rd_val -> wei_val 0 cycles.
REQ-026 Requester whose req_rdy drops after grant is still served; req_addr changes after grant are not observed.
REQ-027 Simultaneous requests: each requester is served at most once per NUM_REQ grants while others are pending (no starvation).
REQ-028 sram_rd_addr holds the latched value outside ISSUE (no glitch requirement on sram_rd_en only).

Reset
REQ-029 rst_n low: state=IDLE, rr_ptr=0, grant=0, latched address=0, sram_rd_en=0, wei_val=0, busy=0, err=0, timeout counter=0, all asynchronously.
REQ-030 reset high in any state: next cycle same values as REQ-029 except err is retained; an outstanding read is abandoned and its later sram_rd_val is ignored per REQ-024; no grant is issued in a cycle where reset is high.

Configuration
REQ-031 Macro WEI_FETCH_ARB_TIMEOUT_EN: when defined, a counter runs in WAIT; if TIMEOUT cycles pass without sram_rd_val, err is set (sticky until rst_n), the state returns to IDLE, rr_ptr advances past the grant, and no wei_val is produced.
REQ-032 Without WEI_FETCH_ARB_TIMEOUT_EN: no counter is built, WAIT waits indefinitely, err is tied 0.

Verification
REQ-033 Single request: req_rdy=4'b0010, req_addr[1]=8'h05, rd latency 3 -> sram_rd_en at cycle+2 with addr {2'd1,8'h05}; wei_val=4'b0010 when sram_rd_val arrives; busy low the next cycle.
REQ-034 Round-robin: req_rdy=4'b1111 held -> grant order 0,1,2,3,0; exactly one sram_rd_en per grant.
REQ-035 Reset mid-WAIT: reset pulse after sram_rd_en, then sram_rd_val -> wei_val stays 0, state IDLE, rr_ptr=0.
REQ-036 Stray valid: sram_rd_val pulsed in IDLE -> wei_val=0, busy=0.
REQ-037 Timeout (macro defined, TIMEOUT=64): no sram_rd_val for 64 cycles -> err=1, busy=0, next request granted to following index; macro undefined -> busy stays 1, err=0.
REQ-038 rst_n asserted in WAIT -> all outputs zero immediately, without clock edge.
